flat_mem_ctrl: RTL and testbench

FLAT_MEM_CTRL -- requirements
Module: flat_mem_ctrl

---
 rtl/flat_mem_ctrl_pkg.sv | 23 ++
 rtl/flat_mem_tag_pipe.sv | 43 ++++
 rtl/flat_mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_flat_mem_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flat_mem_ctrl_pkg.sv
// Shared defaults, FSM encoding and tag payload for the flat image-memory controller.
package flat_mem_ctrl_pkg;

  localparam int unsigned IMWIDTH_DEF      = 240;
  localparam int unsigned IMHEIGHT_DEF     = 180;
  localparam int unsigned RD_LATENCY_DEF   = 4;
  localparam int unsigned WR_BURST_MAX_DEF = 8;
  localparam int unsigned COORD_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pix_tag_t;

endpackage

// File: rtl/flat_mem_tag_pipe.sv
// Coordinate tag pipeline that freezes together with the RAM read pipeline on write cycles.
module flat_mem_tag_pipe
  import flat_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = RD_LATENCY_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     adv_i,
  input  pix_tag_t tag_i,
  output pix_tag_t tag_o,
  output logic     pix_valid_o,
  output logic     empty_next_o
);

  pix_tag_t stage_q [DEPTH];
  logic     adv_q;
  logic     pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      adv_q <= 1'b0;
    end else begin
      adv_q <= adv_i;
      if (adv_i) begin
        stage_q[0] <= tag_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // The last stage is always delivered in the cycle it arrives, so only earlier stages count as pending.
  always_comb begin
    pending = tag_i.valid;
    for (int i = 0; i < DEPTH - 1; i++) pending = pending | stage_q[i].valid;
    empty_next_o = ~pending;
  end

  assign tag_o       = stage_q[DEPTH-1];
  assign pix_valid_o = stage_q[DEPTH-1].valid & adv_q;

endmodule

// File: rtl/flat_mem_ctrl.sv
// Image RAM arbiter: write port versus raster scan reader with stall-aware pixel tagging.
// Optional fair arbitration enabled by defining FLAT_MEM_CTRL_FAIR_ARB_EN.
module flat_mem_ctrl
  import flat_mem_ctrl_pkg::*;
#(
  parameter int unsigned IMWIDTH    = IMWIDTH_DEF,
  parameter int unsigned IMHEIGHT   = IMHEIGHT_DEF,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
`ifdef FLAT_MEM_CTRL_FAIR_ARB_EN
  , parameter int unsigned WR_BURST_MAX = WR_BURST_MAX_DEF
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scanStart,
  output logic               scanBusy,
  output logic               scanDone,
  input  logic               wrReq,
  input  logic [COORD_W-1:0] wrX,
  input  logic [COORD_W-1:0] wrY,
  input  logic               wrData,
  output logic               wrAck,
  output logic [COORD_W-1:0] xAddressOut,
  output logic [COORD_W-1:0] yAddressOut,
  output logic               dataOutMem,
  output logic               write,
  input  logic               memDataIn,
  output logic               pixValid,
  output logic               pixData,
  output logic [COORD_W-1:0] pixX,
  output logic [COORD_W-1:0] pixY
);

  scan_state_e        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               force_scan, grant, scan_rd, last_pix, drain_done;
  pix_tag_t           tag_in, tag_out;

`ifdef FLAT_MEM_CTRL_FAIR_ARB_EN
  localparam int unsigned BW = $clog2(WR_BURST_MAX + 1);
  logic [BW-1:0] burst_q, burst_d;

  // Saturating count of back-to-back write grants; any non-write cycle clears it.
  always_comb begin
    burst_d = '0;
    if (grant) burst_d = (burst_q == BW'(WR_BURST_MAX)) ? burst_q : burst_q + BW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) burst_q <= '0;
    else        burst_q <= burst_d;
  end

  assign force_scan = (state_q == ST_SCAN) && (burst_q >= BW'(WR_BURST_MAX));
`else
  assign force_scan = 1'b0;
`endif

  assign grant    = reset & wrReq & ~force_scan;
  assign scan_rd  = (state_q == ST_SCAN) & ~grant;
  assign last_pix = scan_rd && (x_q == COORD_W'(IMWIDTH - 1)) && (y_q == COORD_W'(IMHEIGHT - 1));

  assign wrAck       = grant;
  assign write       = grant;
  assign dataOutMem  = grant & wrData;
  assign xAddressOut = grant ? wrX : x_q;
  assign yAddressOut = grant ? wrY : y_q;

  // Raster counters advance only on issued scan reads.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (scan_rd) begin
      if (x_q == COORD_W'(IMWIDTH - 1)) begin
        x_d = '0;
        y_d = last_pix ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (scanStart)  state_d = ST_SCAN;
      ST_SCAN:  if (last_pix)   state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    scanBusy = 1'b0;
    scanDone = 1'b0;
    case (state_q)
      ST_SCAN, ST_DRAIN: scanBusy = 1'b1;
      ST_DONE:           scanDone = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = scan_rd;
    tag_in.x     = x_q;
    tag_in.y     = y_q;
  end

  flat_mem_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .clk          (clk),
    .rst_n        (reset),
    .adv_i        (~grant),
    .tag_i        (tag_in),
    .tag_o        (tag_out),
    .pix_valid_o  (pixValid),
    .empty_next_o (drain_done)
  );

  assign pixX    = tag_out.x;
  assign pixY    = tag_out.y;
  assign pixData = memDataIn;

endmodule

// File: tb/tb_flat_mem_ctrl.sv
// Randomized bench for flat_mem_ctrl with a frozen-on-write RAM model and a raster/image reference.
module tb_flat_mem_ctrl;

  localparam int W      = 240;
  localparam int H      = 180;
  localparam int NPIX   = W * H;
  localparam int RD_LAT = 4;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        d;
    int unsigned cyc;
  } pix_obs_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       d;
  } wr_rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scanStart = 1'b0;
  logic       scanBusy, scanDone;
  logic       wrReq = 1'b0;
  logic [7:0] wrX = '0, wrY = '0;
  logic       wrData = 1'b0;
  logic       wrAck;
  logic [7:0] xAddressOut, yAddressOut;
  logic       dataOutMem, write;
  logic       memDataIn;
  logic       pixValid, pixData;
  logic [7:0] pixX, pixY;

  bit          mem     [256][256];
  bit          ref_img [256][256];
  bit [RD_LAT-1:0] rd_pipe;
  pix_obs_t    pix_log [$];
  wr_rec_t     pend_wr [$];
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned scan_start_cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  flat_mem_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .scanStart   (scanStart),
    .scanBusy    (scanBusy),
    .scanDone    (scanDone),
    .wrReq       (wrReq),
    .wrX         (wrX),
    .wrY         (wrY),
    .wrData      (wrData),
    .wrAck       (wrAck),
    .xAddressOut (xAddressOut),
    .yAddressOut (yAddressOut),
    .dataOutMem  (dataOutMem),
    .write       (write),
    .memDataIn   (memDataIn),
    .pixValid    (pixValid),
    .pixData     (pixData),
    .pixX        (pixX),
    .pixY        (pixY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM whose read pipeline holds still on write cycles.
  always @(posedge clk) begin
    if (write === 1'b1) mem[xAddressOut][yAddressOut] <= dataOutMem;
    else rd_pipe <= {rd_pipe[RD_LAT-2:0], mem[xAddressOut][yAddressOut]};
  end
  assign memDataIn = rd_pipe[RD_LAT-1];

  always @(negedge clk) begin
    if (pixValid === 1'b1) pix_log.push_back('{pixX, pixY, pixData, cyc});
    if (scanDone === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic do_write(input logic [7:0] x, input logic [7:0] y, input logic d, output bit acked);
    acked = 1'b0;
    @(negedge clk);
    wrReq = 1'b1; wrX = x; wrY = y; wrData = d;
    for (int i = 0; i < 100 && !acked; i++) begin
      #1;
      if (wrAck === 1'b1) acked = 1'b1;
      @(negedge clk);
    end
    wrReq = 1'b0;
  endtask

  task automatic test_reset();
    wrReq = 1'b1; wrX = 8'h55; wrY = 8'h2A; wrData = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (wrAck !== 1'b0) begin n_bad++; $display("FAIL reset_wrAck got %b want 0", wrAck); end
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL reset_write got %b want 0", write); end
    n_cmp++; if ({xAddressOut, yAddressOut} !== 16'h0) begin n_bad++; $display("FAIL reset_addr got %h/%h want 0/0", xAddressOut, yAddressOut); end
    n_cmp++; if (dataOutMem !== 1'b0) begin n_bad++; $display("FAIL reset_wdata got %b want 0", dataOutMem); end
    n_cmp++; if ({scanBusy, scanDone, pixValid} !== 3'b000) begin n_bad++; $display("FAIL reset_status got %b want 000", {scanBusy, scanDone, pixValid}); end
    n_cmp++; if ({pixX, pixY} !== 16'h0) begin n_bad++; $display("FAIL reset_pixxy got %h/%h want 0/0", pixX, pixY); end
    @(negedge clk);
    wrReq = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({scanBusy, wrAck} !== 2'b00) begin n_bad++; $display("FAIL idle_after_reset got %b want 00", {scanBusy, wrAck}); end
  endtask

  task automatic test_prescan_writes();
    bit acked;
    int n_nak = 0;
    do_write(8'd5, 8'd3, 1'b1, acked);
    if (acked) ref_img[5][3] = 1'b1;
    n_cmp++; if (acked !== 1'b1) begin n_bad++; $display("FAIL write_5_3_ack got %b want 1", acked); end
    for (int k = 0; k < 20; k++) begin
      logic [7:0] x, y;
      logic d;
      x = 8'($urandom_range(W - 1));
      y = 8'($urandom_range(H - 1));
      d = 1'($urandom);
      if (x == 8'd5 && y == 8'd3) d = 1'b1;
      do_write(x, y, d, acked);
      if (acked) ref_img[x][y] = d; else n_nak++;
    end
    n_cmp++; if (n_nak !== 0) begin n_bad++; $display("FAIL idle_writes_unacked got %0d want 0", n_nak); end
  endtask

  task automatic test_scan_start();
    @(negedge clk);
    scanStart = 1'b1;
    scan_start_cyc = cyc;
    #1;
    n_cmp++; if (scanBusy !== 1'b0) begin n_bad++; $display("FAIL busy_on_start_cycle got %b want 0", scanBusy); end
    @(negedge clk);
    scanStart = 1'b0;
    #1;
    n_cmp++; if (scanBusy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start got %b want 1", scanBusy); end
  endtask

  task automatic test_ignored_start();
    repeat (10) @(negedge clk);
    scanStart = 1'b1;
    @(negedge clk);
    scanStart = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ({scanBusy, done_cnt} !== {1'b1, 32'd0}) begin n_bad++; $display("FAIL start_while_busy busy=%b done=%0d want busy=1 done=0", scanBusy, done_cnt); end
  endtask

  task automatic test_write_stall(input int min_pix);
    logic [7:0] ax, ay, ex, ey, sx;
    logic sd;
    int nak = 0;
    for (int i = 0; i < 5000 && pix_log.size() < min_pix; i++) @(negedge clk);
    n_cmp++; if (pix_log.size() < min_pix) begin n_bad++; $display("FAIL stall_wait_pix got %0d want >=%0d", pix_log.size(), min_pix); end
    @(negedge clk);
    #1;
    ax = xAddressOut; ay = yAddressOut;
    n_cmp++; if (wrAck !== 1'b0) begin n_bad++; $display("FAIL ack_without_req got %b want 0", wrAck); end
    ex = (ax == 8'(W - 1)) ? 8'd0 : ax + 8'd1;
    ey = (ax == 8'(W - 1)) ? ay + 8'd1 : ay;
    sx = 8'($urandom_range(W - 1));
    sd = 1'($urandom);
    @(negedge clk);
    wrReq = 1'b1; wrX = sx; wrY = 8'd0; wrData = sd;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (wrAck !== 1'b1 || xAddressOut !== sx || yAddressOut !== 8'd0) nak++;
      @(negedge clk);
    end
    wrReq = 1'b0;
    pend_wr.push_back('{sx, 8'd0, sd});
    #1;
    n_cmp++; if (nak !== 0) begin n_bad++; $display("FAIL stall_grants bad_cycles=%0d want 0", nak); end
    n_cmp++; if ({xAddressOut, yAddressOut} !== {ex, ey}) begin n_bad++; $display("FAIL stall_scan_addr got (%0d,%0d) want (%0d,%0d)", xAddressOut, yAddressOut, ex, ey); end
  endtask

  task automatic test_write_hold();
    logic [7:0] hx;
    logic hd, exp_ack;
    int pat_bad = 0, scans = 0, exp_scans;
    hx = 8'($urandom_range(W - 1));
    hd = 1'($urandom);
    @(negedge clk);
    wrReq = 1'b1; wrX = hx; wrY = 8'd1; wrData = hd;
    for (int k = 0; k < 27; k++) begin
      #1;
`ifdef FLAT_MEM_CTRL_FAIR_ARB_EN
      exp_ack = ((k % 9) != 8);
`else
      exp_ack = 1'b1;
`endif
      if (wrAck !== exp_ack) pat_bad++;
      if (wrAck === 1'b0) scans++;
      @(negedge clk);
    end
    wrReq = 1'b0;
    pend_wr.push_back('{hx, 8'd1, hd});
`ifdef FLAT_MEM_CTRL_FAIR_ARB_EN
    exp_scans = 3;
`else
    exp_scans = 0;
`endif
    n_cmp++; if (pat_bad !== 0) begin n_bad++; $display("FAIL hold_ack_pattern bad_cycles=%0d want 0", pat_bad); end
    n_cmp++; if (scans !== exp_scans) begin n_bad++; $display("FAIL hold_scan_reads got %0d want %0d", scans, exp_scans); end
  endtask

  task automatic test_scan_complete(input int base);
    int n, bad = 0, first_bad = -1;
    logic [7:0] fx, fy, lx, ly;
    logic d53;
    int unsigned fcyc, lcyc;
    for (int i = 0; i < 60000 && done_cnt == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    n = pix_log.size() - base;
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL scan_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (n !== NPIX) begin n_bad++; $display("FAIL scan_pix_count got %0d want %0d", n, NPIX); end
    fx = (n > 0) ? pix_log[base].x : 8'hxx;
    fy = (n > 0) ? pix_log[base].y : 8'hxx;
    fcyc = (n > 0) ? pix_log[base].cyc : 0;
    lx = (n > 0) ? pix_log[base + n - 1].x : 8'hxx;
    ly = (n > 0) ? pix_log[base + n - 1].y : 8'hxx;
    lcyc = (n > 0) ? pix_log[base + n - 1].cyc : 0;
    d53 = (n > 725) ? pix_log[base + 725].d : 1'bx;
    n_cmp++; if ({fx, fy} !== 16'h0) begin n_bad++; $display("FAIL first_pix got (%0d,%0d) want (0,0)", fx, fy); end
    n_cmp++; if (fcyc !== scan_start_cyc + 5) begin n_bad++; $display("FAIL first_pix_latency got %0d want %0d", fcyc - scan_start_cyc, 5); end
    n_cmp++; if ({lx, ly} !== {8'(W - 1), 8'(H - 1)}) begin n_bad++; $display("FAIL last_pix got (%0d,%0d) want (%0d,%0d)", lx, ly, W - 1, H - 1); end
    n_cmp++; if (done_cyc !== lcyc + 1) begin n_bad++; $display("FAIL done_timing got %0d want %0d", done_cyc, lcyc + 1); end
    n_cmp++; if (d53 !== 1'b1) begin n_bad++; $display("FAIL pixel_5_3 got %b want 1", d53); end
    for (int i = 0; i < n && i < NPIX; i++) begin
      logic [7:0] ex, ey;
      ex = 8'(i % W);
      ey = 8'(i / W);
      if (pix_log[base + i].x !== ex || pix_log[base + i].y !== ey || pix_log[base + i].d !== ref_img[ex][ey]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL scan_raster bad=%0d first_bad_index=%0d want 0", bad, first_bad); end
    foreach (pend_wr[i]) ref_img[pend_wr[i].x][pend_wr[i].y] = pend_wr[i].d;
    pend_wr.delete();
  endtask

  task automatic test_reset_mid_scan();
    int base, after, done0;
    test_scan_start();
    base = pix_log.size();
    done0 = done_cnt;
    for (int i = 0; i < 3000 && pix_log.size() < base + 1000; i++) @(negedge clk);
    n_cmp++; if (pix_log.size() < base + 1000) begin n_bad++; $display("FAIL abort_wait_pix got %0d want %0d", pix_log.size() - base, 1000); end
    reset = 1'b0;
    wrReq = 1'b1; wrX = 8'd77; wrY = 8'd66; wrData = 1'b1;
    #1;
    after = pix_log.size();
    n_cmp++; if ({scanBusy, scanDone, pixValid, pixX, pixY} !== 19'h0) begin n_bad++; $display("FAIL abort_outputs got busy=%b done=%b pv=%b xy=(%0d,%0d) want all 0", scanBusy, scanDone, pixValid, pixX, pixY); end
    n_cmp++; if ({wrAck, write, xAddressOut, yAddressOut} !== 18'h0) begin n_bad++; $display("FAIL abort_comb got ack=%b wr=%b addr=(%0d,%0d) want all 0", wrAck, write, xAddressOut, yAddressOut); end
    repeat (3) @(negedge clk);
    wrReq = 1'b0;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if ({done_cnt - done0, pix_log.size() - after} !== 64'h0) begin n_bad++; $display("FAIL abort_silent done=%0d pix=%0d want 0/0", done_cnt - done0, pix_log.size() - after); end
  endtask

  task automatic test_restart();
    int base, n, bad = 0, first_bad = -1;
    test_scan_start();
    base = pix_log.size();
    for (int i = 0; i < 1000 && pix_log.size() < base + 300; i++) @(negedge clk);
    n = pix_log.size() - base;
    n_cmp++; if (n < 300) begin n_bad++; $display("FAIL restart_pix_count got %0d want >=300", n); end
    n_cmp++; if (((n > 0) ? pix_log[base].cyc : 0) !== scan_start_cyc + 5) begin n_bad++; $display("FAIL restart_latency got %0d want %0d", (n > 0) ? pix_log[base].cyc : 0, scan_start_cyc + 5); end
    for (int i = 0; i < n && i < 300; i++) begin
      logic [7:0] ex, ey;
      ex = 8'(i % W);
      ey = 8'(i / W);
      if (pix_log[base + i].x !== ex || pix_log[base + i].y !== ey || pix_log[base + i].d !== ref_img[ex][ey]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL restart_raster bad=%0d first_bad_index=%0d want 0", bad, first_bad); end
  endtask

  initial begin
    int base;
    test_reset();
    test_prescan_writes();
    base = pix_log.size();
    test_scan_start();
    test_ignored_start();
    test_write_stall(1200);
    test_write_stall(1300);
    test_write_stall(1400);
    test_write_hold();
    test_scan_complete(base);
    test_reset_mid_scan();
    test_restart();
    reset = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
